split_access_memory: RTL and testbench

//  Byte-addressed data memory for the CPU. Serves 1..LANES-byte little-endian loads/stores at any byte address.

---
 rtl/memory_pkg.sv | 23 ++
 rtl/split_access_memory_row_ram.sv | 31 +++
 rtl/split_access_memory.sv | 205 ++++++++++++++++++++
 tb/tb_split_access_memory.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and sizing helpers for the split-access byte memory.
package memory_pkg;

  localparam int DEF_BBW        = 8;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_LANES      = 4;
  localparam int DEF_WRAP       = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic int len_w(input int lanes);
    return $clog2(lanes);
  endfunction

  function automatic int rows(input int addr_width, input int lanes);
    return (2 ** addr_width) / lanes;
  endfunction

endpackage

// File: rtl/split_access_memory_row_ram.sv
// Row-wide synchronous-read RAM with per-lane write enables.
// Read data is registered and holds whenever the port is idle.
module row_ram #(
  parameter int ROWS  = 1024,
  parameter int AW    = 10,
  parameter int LANES = 4,
  parameter int BBW   = 8
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [AW-1:0]          addr,
  input  logic [LANES-1:0]       wen,
  input  logic [LANES*BBW-1:0]   wdata,
  output logic [LANES*BBW-1:0]   rdata
);

  logic [LANES*BBW-1:0] mem [ROWS];
  logic [LANES*BBW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wen[l]) mem[addr][l*BBW +: BBW] <= wdata[l*BBW +: BBW];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/split_access_memory.sv
// Byte-addressed data memory: 1..LANES-byte little-endian accesses at any
// address, with row-crossing accesses split over two RAM cycles.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ready for a request; first row accessed on accept
//   ST_SPLIT | second row (r+1, or row 0 when wrapping) being accessed
//   ST_RESP  | response presented, held until rsp_ready
module split_access_memory
  import memory_pkg::*;
#(
  parameter int BASE_BIT_WIDTH = DEF_BBW,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LANES          = DEF_LANES,
  parameter int WRAP           = DEF_WRAP
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [$clog2(LANES)-1:0]          req_dlen,
  input  logic [LANES*BASE_BIT_WIDTH-1:0]   req_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [LANES*BASE_BIT_WIDTH-1:0]   rsp_q,
  output logic                              rsp_trunc
);

  localparam int LEN_W = len_w(LANES);
  localparam int RAW   = ADDR_WIDTH - LEN_W;
  localparam int BBW   = BASE_BIT_WIDTH;
  localparam int DW    = LANES * BBW;
  localparam int PW    = LEN_W + 2;

  state_e state_q, state_d;

  logic [RAW-1:0]   row_q,   row_d;
  logic [LEN_W-1:0] off_q,   off_d;
  logic [LEN_W-1:0] dlen_q,  dlen_d;
  logic             we_q,    we_d;
  logic [DW-1:0]    data_q,  data_d;
  logic             split_q, split_d;
  logic             trunc_q, trunc_d;
  logic [DW-1:0]    first_q, first_d;

  logic [RAW-1:0]   cur_row;
  logic [LEN_W-1:0] cur_off;
  logic [LEN_W-1:0] cur_dlen;
  logic             cur_we;
  logic [DW-1:0]    cur_data;
  logic [PW-1:0]    end_pos;
  logic             is_split;
  logic             at_top;
  logic [LANES-1:0] first_mask;
  logic [LANES-1:0] second_mask;
  logic [LEN_W-1:0] src;
  logic [DW-1:0]    rot_data;

  logic             ram_en;
  logic [RAW-1:0]   ram_addr;
  logic [LANES-1:0] ram_wen;
  logic [DW-1:0]    ram_rdata;

  logic [PW-1:0]    pos;
  logic [LEN_W-1:0] lane;

  logic accept;
  assign accept = (state_q == ST_IDLE) && req_valid;

  // In IDLE the live request drives the RAM; in SPLIT the latched copy does.
  always_comb begin
    cur_row  = row_q;
    cur_off  = off_q;
    cur_dlen = dlen_q;
    cur_we   = we_q;
    cur_data = data_q;
    if (state_q == ST_IDLE) begin
      cur_row  = req_addr[ADDR_WIDTH-1:LEN_W];
      cur_off  = req_addr[LEN_W-1:0];
      cur_dlen = req_dlen;
      cur_we   = req_we;
      cur_data = req_data;
    end
    end_pos  = PW'(cur_off) + PW'(cur_dlen) + PW'(1);
    is_split = end_pos > PW'(LANES);
    at_top   = &cur_row;
    src      = '0;
    rot_data = '0;
    for (int l = 0; l < LANES; l++) begin
      first_mask[l]  = (PW'(l) >= PW'(cur_off)) && (PW'(l) < end_pos);
      second_mask[l] = PW'(l + LANES) < end_pos;
      src            = LEN_W'(l) - cur_off;
      rot_data[l*BBW +: BBW] = cur_data[src*BBW +: BBW];
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_addr = cur_row;
    ram_wen  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ram_en  = 1'b1;
          ram_wen = cur_we ? first_mask : '0;
        end
      end
      ST_SPLIT: begin
        if (!trunc_q) begin
          ram_en   = 1'b1;
          ram_addr = row_q + RAW'(1);
          ram_wen  = we_q ? second_mask : '0;
        end
      end
      default: ;
    endcase
    ram_wen = ram_wen & {LANES{rst_n}};
  end

  row_ram #(
    .ROWS  (rows(ADDR_WIDTH, LANES)),
    .AW    (RAW),
    .LANES (LANES),
    .BBW   (BBW)
  ) u_row_ram (
    .clk   (clk),
    .en    (ram_en),
    .addr  (ram_addr),
    .wen   (ram_wen),
    .wdata (rot_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = is_split ? ST_SPLIT : ST_RESP;
      ST_SPLIT: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d   = row_q;
    off_d   = off_q;
    dlen_d  = dlen_q;
    we_d    = we_q;
    data_d  = data_q;
    split_d = split_q;
    trunc_d = trunc_q;
    first_d = first_q;
    if (accept) begin
      row_d   = cur_row;
      off_d   = cur_off;
      dlen_d  = cur_dlen;
      we_d    = cur_we;
      data_d  = cur_data;
      split_d = is_split;
      trunc_d = is_split && at_top && (WRAP == 0);
    end
    if (state_q == ST_SPLIT) first_d = ram_rdata;
  end

  always_ff @(posedge clk) begin
    row_q   <= row_d;
    off_q   <= off_d;
    dlen_q  <= dlen_d;
    we_q    <= we_d;
    data_q  <= data_d;
    split_q <= split_d;
    trunc_q <= trunc_d;
    first_q <= first_d;
  end

  // Byte k lives in lane (off+k)%LANES; bytes past the row end come from the second row.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_trunc = (state_q == ST_RESP) && trunc_q;
    rsp_q     = '0;
    pos       = '0;
    lane      = '0;
    if ((state_q == ST_RESP) && !we_q) begin
      for (int k = 0; k < LANES; k++) begin
        pos  = PW'(off_q) + PW'(k);
        lane = off_q + LEN_W'(k);
        if (k <= int'(dlen_q)) begin
          if (pos < PW'(LANES))
            rsp_q[k*BBW +: BBW] = split_q ? first_q[lane*BBW +: BBW] : ram_rdata[lane*BBW +: BBW];
          else if (!trunc_q)
            rsp_q[k*BBW +: BBW] = ram_rdata[lane*BBW +: BBW];
        end
      end
    end
  end

endmodule

// File: tb/tb_split_access_memory.sv
// Directed bench for split_access_memory: one WRAP=0 and one WRAP=1 instance,
// expected responses queued at request time and compared on response.
module tb_split_access_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [11:0] req_addr;
  logic [1:0]  req_dlen;
  logic [31:0] req_data;
  logic        rsp_ready;

  logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_trunc0, rsp_trunc1;
  logic [31:0] rsp_q0, rsp_q1;
  logic        req_ready_m, rsp_valid_m, rsp_trunc_m;
  logic [31:0] rsp_q_m;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] q;
    logic        trunc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  split_access_memory #(.WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_dlen(req_dlen), .req_data(req_data),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_q(rsp_q0), .rsp_trunc(rsp_trunc0)
  );

  split_access_memory #(.WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_dlen(req_dlen), .req_data(req_data),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_q(rsp_q1), .rsp_trunc(rsp_trunc1)
  );

  assign req_ready_m = sel ? req_ready1 : req_ready0;
  assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid0;
  assign rsp_trunc_m = sel ? rsp_trunc1 : rsp_trunc0;
  assign rsp_q_m     = sel ? rsp_q1     : rsp_q0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!rsp_valid_m && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/rsp_valid"}, 32'(rsp_valid_m), 32'd1);
    if (rsp_valid_m && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "/latency"}, 32'(lat), 32'(e.lat));
      check({tag, "/rsp_q"}, rsp_q_m, e.q);
      check({tag, "/rsp_trunc"}, 32'(rsp_trunc_m), 32'(e.trunc));
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [11:0] addr,
                        input logic [1:0] dlen, input logic [31:0] data,
                        input logic [31:0] exp_q, input logic exp_trunc, input int exp_lat);
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready_m), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_dlen  = dlen;
    req_data  = data;
    sb.push_back('{q: exp_q, trunc: exp_trunc, lat: exp_lat});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(tag);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_dlen = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset0/req_ready", 32'(req_ready0), 32'd1);
    check("reset0/rsp_valid", 32'(rsp_valid0), 32'd0);
    check("reset0/rsp_q", rsp_q0, 32'd0);
    check("reset0/rsp_trunc", 32'(rsp_trunc0), 32'd0);
    check("reset1/req_ready", 32'(req_ready1), 32'd1);
    check("reset1/rsp_valid", 32'(rsp_valid1), 32'd0);
    rst_n = 1'b1;

    // Aligned full-row store and load
    do_req("t1_st",  1'b1, 12'h010, 2'd3, 32'hDDCCBBAA, 32'h0, 1'b0, 1);
    do_req("t1_ld",  1'b0, 12'h010, 2'd3, 32'h0, 32'hDDCCBBAA, 1'b0, 1);
    do_req("t1_ld2", 1'b0, 12'h011, 2'd1, 32'h0, 32'h0000CCBB, 1'b0, 1);

    // Row-crossing accesses
    do_req("t2_st",  1'b1, 12'h013, 2'd3, 32'h44332211, 32'h0, 1'b0, 2);
    do_req("t2_ld",  1'b0, 12'h013, 2'd3, 32'h0, 32'h44332211, 1'b0, 2);
    do_req("t2_ld1", 1'b0, 12'h014, 2'd0, 32'h0, 32'h00000022, 1'b0, 1);
    do_req("t2_ld2", 1'b0, 12'h010, 2'd3, 32'h0, 32'h11CCBBAA, 1'b0, 1);

    // Top of memory, truncating instance
    do_req("t3_st0", 1'b1, 12'h000, 2'd1, 32'h0000BEEF, 32'h0, 1'b0, 1);
    do_req("t3_st",  1'b1, 12'hFFE, 2'd3, 32'h87654321, 32'h0, 1'b1, 2);
    do_req("t3_ld",  1'b0, 12'hFFE, 2'd3, 32'h0, 32'h00004321, 1'b1, 2);
    do_req("t3_ld0", 1'b0, 12'h000, 2'd1, 32'h0, 32'h0000BEEF, 1'b0, 1);

    // Top of memory, wrapping instance
    sel = 1'b1;
    do_req("t4_st0", 1'b1, 12'h000, 2'd1, 32'h0000BEEF, 32'h0, 1'b0, 1);
    do_req("t4_st",  1'b1, 12'hFFE, 2'd3, 32'h87654321, 32'h0, 1'b0, 2);
    do_req("t4_ld",  1'b0, 12'hFFE, 2'd3, 32'h0, 32'h87654321, 1'b0, 2);
    do_req("t4_ld0", 1'b0, 12'h000, 2'd1, 32'h0, 32'h00008765, 1'b0, 1);
    sel = 1'b0;

    // Back-pressure with a request kept pending
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_dlen = 2'd3; req_data = '0;
    sb.push_back('{q: 32'h11CCBBAA, trunc: 1'b0, lat: 1});
    @(posedge clk);
    @(negedge clk);
    wait_rsp("t5_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold/rsp_valid", 32'(rsp_valid_m), 32'd1);
      check("t5_hold/rsp_q", rsp_q_m, 32'h11CCBBAA);
      check("t5_hold/req_ready", 32'(req_ready_m), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_after/rsp_valid", 32'(rsp_valid_m), 32'd0);
    check("t5_after/req_ready", 32'(req_ready_m), 32'd1);
    @(negedge clk);
    check("t5_after2/rsp_valid", 32'(rsp_valid_m), 32'd0);

    // Reset during the second-row cycle of a split store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h013; req_dlen = 2'd3; req_data = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst/rsp_valid", 32'(rsp_valid_m), 32'd0);
    check("t6_rst/req_ready", 32'(req_ready_m), 32'd1);
    do_req("t6_ld13", 1'b0, 12'h013, 2'd0, 32'h0, 32'h000000DD, 1'b0, 1);
    do_req("t6_ld14", 1'b0, 12'h014, 2'd0, 32'h0, 32'h00000022, 1'b0, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
